// File: rtl/hack_arb_pkg.sv
// Shared constants and types for the 8-requester round-robin arbiter family.
package hack_arb_pkg;
    localparam int unsigned N_REQ  = 8;
    localparam int unsigned DW     = 16;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [DW-1:0]    word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set bit of req searching start, start+1, ... mod 8.
module rr_pick8
    import hack_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             start,
    output logic             any,
    output sel_t             idx,
    output logic [N_REQ-1:0] onehot
);

    sel_t cand;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = start + sel_t'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        onehot[idx] = any;
    end

endmodule

// File: rtl/arb8way16_rr.sv
// 8-way round-robin arbiter feeding a single-entry 16-bit output register.
// Optional winner hold for up to MAX_HOLD beats when ARB_HOLD_EN is defined.
module arb8way16_rr
    import hack_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  word_t            d0,
    input  word_t            d1,
    input  word_t            d2,
    input  word_t            d3,
    input  word_t            d4,
    input  word_t            d5,
    input  word_t            d6,
    input  word_t            d7,
    output logic             out_valid,
    output word_t            out_data,
    output sel_t             out_src,
    input  logic             out_ready
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..15");
    end

    state_t           state;
    state_t           state_nxt;
    sel_t             last_grant;
    sel_t             start;
    logic             any_valid;
    sel_t             win_idx;
    logic [N_REQ-1:0] win_oh;
    logic             load;
    logic             accept;
    word_t            win_data;

`ifdef ARB_HOLD_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_on;

    // Starting the search at last_grant itself keeps the current winner on top.
    assign hold_on = req_valid[last_grant] && (hold_cnt != '0) &&
                     (hold_cnt < HOLD_W'(MAX_HOLD));
    assign start   = hold_on ? last_grant : last_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (accept) begin
            if (win_idx == last_grant && hold_cnt != '0) begin
                if (hold_cnt != '1)
                    hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= HOLD_W'(1);
            end
        end
    end
`else
    assign start = last_grant + 1'b1;
`endif

    rr_pick8 u_pick (
        .req    (req_valid),
        .start  (start),
        .any    (any_valid),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    assign load      = !out_valid || out_ready;
    assign accept    = load && any_valid;
    assign req_ready = win_oh & {N_REQ{accept && rst_n}};

    always_comb begin
        win_data = '0;
        case (win_idx)
            3'd0:    win_data = d0;
            3'd1:    win_data = d1;
            3'd2:    win_data = d2;
            3'd3:    win_data = d3;
            3'd4:    win_data = d4;
            3'd5:    win_data = d5;
            3'd6:    win_data = d6;
            default: win_data = d7;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (!accept && out_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= sel_t'(N_REQ - 1);
        end else if (accept) begin
            out_data   <= win_data;
            out_src    <= win_idx;
            last_grant <= win_idx;
        end
    end

endmodule

// File: tb/tb_arb8way16_rr.sv
// Directed bench for arb8way16_rr with a rule-level reference model checked every cycle.
module tb_arb8way16_rr;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req_valid;
    logic [7:0]  req_ready;
    logic [15:0] d [8];
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_src;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

`ifdef ARB_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    arb8way16_rr #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .d4        (d[4]),
        .d5        (d[5]),
        .d6        (d[6]),
        .d7        (d[7]),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the winner is the first valid requester after the last grant,
    // unless the last grantee is still valid and has had fewer than 4 consecutive beats.
    function automatic int pick(input logic [7:0] v, input int last, input int hc);
        if (HOLD_EN && hc > 0 && hc < 4 && v[last]) return last;
        for (int k = 1; k <= 8; k++)
            if (v[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    bit          m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_last;
    int          m_hc;

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 16'h0000;
            m_src   = 0;
            m_last  = 7;
            m_hc    = 0;
        end else begin
            w = pick(req_valid, m_last, m_hc);
            if ((!m_valid || out_ready) && w >= 0) begin
                m_valid = 1'b1;
                m_data  = d[w];
                m_src   = w;
                if (w == m_last && m_hc > 0) m_hc = (m_hc < 15) ? m_hc + 1 : 15;
                else                         m_hc = 1;
                m_last  = w;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic [7:0] exp_ready;
        if (!rst_n) begin
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_data",  32'(out_data),  32'h0);
        end else begin
            w = pick(req_valid, m_last, m_hc);
            exp_ready = ((!m_valid || out_ready) && w >= 0) ? 8'(1 << w) : 8'h00;
            chk("model_ready", 32'(req_ready), 32'(exp_ready));
            chk("model_valid", 32'(out_valid), 32'(m_valid));
            chk("model_data",  32'(out_data),  32'(m_data));
            chk("model_src",   32'(out_src),   32'(m_src));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);

        // Idle after reset
        step(3);
        rst_n = 1'b1;
        step(10);
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_ready", 32'(req_ready), 32'h0);

        // Single requester 3
        d[3] = 16'hBEEF;
        req_valid = 8'h08;
        #1;
        chk("single_ready", 32'(req_ready), 32'h08);
        step(1);
        chk("single_data", 32'(out_data), 32'hBEEF);
        chk("single_src",  32'(out_src),  32'h3);
        chk("single_ready2", 32'(req_ready), 32'h08);
        req_valid = 8'h00;
        step(2);
        chk("single_drain", 32'(out_valid), 32'h0);
        d[3] = 16'h1003;

        // All requesting from reset
        do_reset();
        req_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            int es;
            step(1);
            es = HOLD_EN ? (k / 4) % 8 : k % 8;
            chk("rr_src",  32'(out_src),  32'(es));
            chk("rr_data", 32'(out_data), 32'h1000 + 32'(es));
            chk("rr_valid", 32'(out_valid), 32'h1);
        end
        req_valid = 8'h00;
        step(2);

`ifdef ARB_HOLD_EN
        // Held requester 1 drops after two beats
        do_reset();
        req_valid = 8'hFF;
        step(4);
        chk("hold_src0", 32'(out_src), 32'h0);
        step(2);
        chk("hold_src1", 32'(out_src), 32'h1);
        req_valid = 8'hFD;
        step(1);
        chk("hold_drop", 32'(out_src), 32'h2);
        req_valid = 8'h00;
        step(2);
`endif

        // Backpressure with requesters 0 and 7
        do_reset();
        req_valid = 8'h81;
        out_ready = 1'b0;
        step(1);
        chk("bp_first", 32'(out_src), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data",  32'(out_data),  32'h1000);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        step(1);
        chk("bp_next", 32'(out_src), HOLD_EN ? 32'h0 : 32'h7);
        step(1);
        chk("bp_after", 32'(out_src), 32'h0);
        req_valid = 8'h00;
        step(2);

        // Reset mid-stream
        req_valid = 8'hFF;
        step(3);
        chk("mid_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'h0);
        chk("mid_async_ready", 32'(req_ready), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("mid_first", 32'(out_src), 32'h0);
        chk("mid_first_data", 32'(out_data), 32'h1000);
        req_valid = 8'h00;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb8way16_rr.md
Name: arb8way16_rr

Overview:
- Round-robin arbiter/scheduler sharing one 16-bit output channel among 8 requesters.
- Each requester offers a 16-bit word with valid/ready. The block picks one winner per accepted beat, steers the winner's word through an 8-way 16-bit select, and registers it into a single-entry output stage.
- Sits in front of any shared 16-bit consumer (memory-mapped write port, bus, output device).

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 because the select width is 3.
- DW, 16, data width of each requester word and of the output.
- MAX_HOLD, 4, maximum consecutive beats for one requester; used only when ARB_HOLD_EN is defined; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  8  bit i: requester i offers d_i.
- req_ready  out  8  one-hot or zero: bit i high means d_i is accepted this cycle.
- d0..d7  in  16 each  requester data words.
- out_valid  out  1  output register holds a beat.
- out_data  out  16  registered beat data.
- out_src  out  3  index of the requester that produced out_data.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
- Reset: asynchronous on rst_n low. Required values:
  - out_valid=0, out_data=16'h0000, out_src=3'd0.
  - Round-robin pointer last_grant=3'd7, so requester 0 has first priority.
  - Hold counter=0.
- Combinational outputs while rst_n is low: req_ready=8'h00.
- State: FSM EMPTY/FULL, encoded by out_valid.
  - EMPTY -> FULL on an accept.
  - FULL -> EMPTY on a drain with no accept.
  - FULL -> FULL on a simultaneous drain and accept.
- Load enable: load = !out_valid || out_ready. A drain and a refill in the same cycle is legal and gives full throughput (1 beat/cycle).
- Arbitration (combinational, from req_valid and last_grant only):
  - Search indices last_grant+1, +2, … +8, mod 8.
  - The first index with valid set is the winner.
  - No valid requester means no winner.
- Accept: req_ready = onehot(winner) & {8{load && any_valid}}.
  - On accept: out_data<=d[winner], out_src<=winner, out_valid<=1, last_grant<=winner.
- Drain: out_valid && out_ready && !accept -> out_valid<=0. out_data and out_src keep their old values.
- req_ready never depends on req_ready; there is no combinational loop.
- out_valid/out_data/out_src depend only on registers.
- Requester rule: once valid is asserted, d_i stays stable and valid stays high until ready. The arbiter may change the winner while stalled; that is allowed because the requester holds its offer.
- Latency: accepted word appears on out_data the next cycle.
- Fairness: with all 8 requesting continuously and out_ready=1, grants go 0,1,…,7,0,… and each requester waits at most 7 beats.
- Stall: while FULL and out_ready=0, req_ready=0 and registers hold. last_grant does not advance.
- Reset mid-transfer: the pending output beat is discarded. No req_ready is issued during reset.

Optional Feature:
- Macro: ARB_HOLD_EN.
- With ARB_HOLD_EN defined: the current winner keeps priority for up to MAX_HOLD consecutive accepted beats while its valid stays high.
  - A 4-bit hold_cnt increments on each accept by the same source.
  - It resets to 1 on a source change.
  - When hold_cnt==MAX_HOLD, the search starts at last_grant+1 as normal.
  - If the held requester drops valid, round-robin resumes immediately.
- Without it: pure round-robin, no hold_cnt register, and MAX_HOLD is ignored.

Decomposition:
- Package hack_arb_pkg holds:
  - constants N_REQ=8, DW=16, SEL_W=3, HOLD_W=4;
  - typedefs sel_t (logic [2:0]) and word_t (logic [15:0]).
- One sub-module, rr_pick8: inputs req[7:0] and start[2:0]; outputs any, idx[2:0] and onehot[7:0]. It is purely combinational rotate-and-priority-encode logic, reused by future schedulers.
- Data steering uses the codebase's existing 8-way 16-bit select; no new mux module.

Test Plan:
- Reset then req_valid=8'h00 -> req_ready=0, out_valid stays 0 for 10 cycles.
- Single requester: req_valid=8'h08, d3=16'hBEEF, out_ready=1.
  - req_ready=8'h08 every cycle.
  - Next cycle: out_data=BEEF, out_src=3.
- All requesting, d_i=16'h1000+i, out_ready=1 -> out_src sequence 0,1,2,…,7,0 with out_data 1000..1007, one beat per cycle.
- Backpressure: req_valid=8'h81, out_ready=0 for 5 cycles after the first accept.
  - out_valid=1 and out_data constant; req_ready=0.
  - Then out_ready=1: source 7 is granted next (after 0), then 0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0 asynchronously. After release, the first grant goes to requester 0 when all request.
- ARB_HOLD_EN, MAX_HOLD=4, req_valid=8'hFF held -> out_src sequence 0,0,0,0,1,1,1,1,2… When requester 1 drops valid after 2 beats, the next grant is requester 2.
